controle_bateria: RTL and testbench
===================================

# controle_bateria

Battery-state engine for the vacuum robot; it is the producer side of the battery indicator LED bar. It tracks a 0–9 charge level that drains while the robot runs and refills while docked. It drives the nine-LED bar (`led0`..`led8`) as a thermometer code and raises `bateria_baixa` so the navigation logic can return to base. It gates the motors through `motor_habilitado` when the battery is exhausted.

## Interface
- `TICKS_DESC`, default 50_000_000: clock cycles per one-level discharge step; must be ≥1.
- `TICKS_CARGA`, default 25_000_000: clock cycles per one-level charge step; must be ≥1.
- `NIVEL_BAIXO`, default 2: `bateria_baixa` asserts when `nivel` ≤ this value; range 0..8.
- `CNT_W`, default 26: prescaler width; must hold max(`TICKS_DESC`, `TICKS_CARGA`)−1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ligar`  in  1  robot-on request (the same signal that feeds the indicator's `control`).
- `na_base`  in  1  robot is docked on the charger.
- `nivel`  out  4  current charge level, 0..9.
- `led0`..`led8`  out  1 each  LED bar; `led_i` = (`nivel` > i).
- `bateria_baixa`  out  1  `nivel` ≤ `NIVEL_BAIXO`.
- `carregando`  out  1  state is CARGA.
- `motor_habilitado`  out  1  state is DESCARGA.
- `vazia`  out  1  state is ESGOTADA.

## Operation
States and their behaviour:
- PARADO: `nivel` is held.
- DESCARGA: draining.
- CARGA: charging.
- ESGOTADA: exhausted, `nivel` = 0, motors locked out.

Next-state rules are evaluated every cycle. Priority is `reset` > `na_base` > `ligar`.
- `na_base`=1 and `nivel`<9: go to CARGA, from any state including ESGOTADA.
- `na_base`=1 and `nivel`=9: go to PARADO, even if `ligar`=1. A docked robot never discharges.
- `na_base`=0, state ESGOTADA: stay in ESGOTADA. `ligar` is ignored.
- `na_base`=0, `ligar`=1, otherwise: go to DESCARGA.
- `na_base`=0, `ligar`=0, otherwise: go to PARADO.

Prescaler `cnt`:
- Cleared on every state change and on reset.
- Increments each cycle in DESCARGA and CARGA; held at 0 in PARADO and ESGOTADA.
- DESCARGA, when `cnt`=`TICKS_DESC`−1: `cnt`←0 and `nivel`←`nivel`−1.
  - If that makes `nivel` 0, the state becomes ESGOTADA on the same edge.
- CARGA, when `cnt`=`TICKS_CARGA`−1: `cnt`←0 and `nivel`←`nivel`+1.
  - If that makes `nivel` 9, the state becomes PARADO on the same edge. The charger then goes idle.
- `nivel` saturates: it never goes below 0 or above 9.
- Leaving CARGA or DESCARGA mid-step discards the partial `cnt` progress.

All outputs are derived combinationally from the registered `state` and `nivel`, with no extra register stage.

## Timing
- Reset is asynchronous and takes effect immediately, including mid-step. Reset values:
  - state PARADO, `nivel`=9, `cnt`=0.
  - `led0`..`led8`=1.
  - `bateria_baixa`=0, `carregando`=0, `motor_habilitado`=0, `vazia`=0.
- Input to state latency: `ligar`/`na_base` sampled high at edge e changes the state at edge e. Status outputs reflect it immediately after edge e.
- First decrement after entering DESCARGA at edge e happens at edge e+`TICKS_DESC`. Later decrements follow every `TICKS_DESC` edges.
- The same spacing applies in CARGA with `TICKS_CARGA`.
- A full drain from 9 takes 9·`TICKS_DESC` edges. A full charge from 0 takes 9·`TICKS_CARGA` edges.
- `nivel`, the LEDs and `bateria_baixa` all change on the same edge.
- With `TICKS_*`=1, `nivel` steps every cycle in that state.
- `ligar` and `na_base` are synchronous to `clk`; synchronizing them is the integrator's responsibility.

## Test plan
All scenarios use `TICKS_DESC`=4, `TICKS_CARGA`=2, `NIVEL_BAIXO`=2.
- Reset, then idle:
  - Right after reset: `nivel`=9, all LEDs 1, all flags 0.
  - Assert `reset` mid-DESCARGA: `nivel` returns to 9 asynchronously, before the next edge.
- Full discharge: hold `ligar`=1 from edge 0.
  - `nivel` reads 8 at edge 4 and 7 at edge 8.
  - `bateria_baixa` rises at edge 28 (`nivel`=2).
  - `nivel`=0 at edge 36, with `vazia`=1, `motor_habilitado`=0 and all LEDs 0.
  - Toggling `ligar` afterwards keeps the block in ESGOTADA.
- Recharge from empty: in ESGOTADA, assert `na_base`.
  - `carregando`=1 on the next edge.
  - `nivel` steps +1 every 2 cycles.
  - `nivel`=9 after 18 cycles; state becomes PARADO and `carregando`=0.
- Interrupted charge: at `nivel`=5 with `cnt`=1 in CARGA, drop `na_base` while `ligar`=1.
  - State becomes DESCARGA with `cnt` cleared.
  - `nivel` reads 4 four edges later; the charge step is not completed.
- Dock while on and full: at `nivel`=9, hold `ligar`=1 and `na_base`=1 for 50 cycles.
  - State stays PARADO, `nivel`=9, `motor_habilitado`=0.
- Pause mid-discharge: drop `ligar` at `cnt`=3 in DESCARGA.
  - State becomes PARADO, `nivel` is unchanged and `cnt`=0.
  - On re-asserting `ligar`, the next decrement lands a full 4 edges later.

Source files
------------

// File: rtl/controle_bateria_if.sv
// Signal bundle between the battery-state engine and its consumers.
// Consumers use the master modport and the engine uses the slave modport.
interface controle_bateria_if;
  logic       ligar;
  logic       na_base;
  logic [3:0] nivel;
  logic       led0, led1, led2, led3, led4, led5, led6, led7, led8;
  logic       bateria_baixa;
  logic       carregando;
  logic       motor_habilitado;
  logic       vazia;

  modport master (
    output ligar, na_base,
    input  nivel, led0, led1, led2, led3, led4, led5, led6, led7, led8,
    input  bateria_baixa, carregando, motor_habilitado, vazia
  );

  modport slave (
    input  ligar, na_base,
    output nivel, led0, led1, led2, led3, led4, led5, led6, led7, led8,
    output bateria_baixa, carregando, motor_habilitado, vazia
  );
endinterface

// File: rtl/controle_bateria.sv
// Battery-state engine: a 0..9 charge level drains in DESCARGA and refills in CARGA,
// paced by a shared prescaler. It drives the LED thermometer bar and the motor gate.
module controle_bateria #(
  parameter int TICKS_DESC  = 50_000_000,
  parameter int TICKS_CARGA = 25_000_000,
  parameter int NIVEL_BAIXO = 2,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               reset,
  controle_bateria_if.slave  bus
);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    DESCARGA = 2'd1,
    CARGA    = 2'd2,
    ESGOTADA = 2'd3
  } estado_t;

  localparam logic [3:0]       NIVEL_MAX = 4'd9;
  localparam logic [CNT_W-1:0] FIM_DESC  = CNT_W'(TICKS_DESC - 1);
  localparam logic [CNT_W-1:0] FIM_CARGA = CNT_W'(TICKS_CARGA - 1);

  estado_t          state_q, state_d, alvo;
  logic [3:0]       nivel_q, nivel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    if (bus.na_base)             alvo = (nivel_q < NIVEL_MAX) ? CARGA : PARADO;
    else if (state_q == ESGOTADA) alvo = ESGOTADA;
    else if (bus.ligar)           alvo = DESCARGA;
    else                          alvo = PARADO;

    state_d = alvo;
    nivel_d = nivel_q;
    cnt_d   = '0;

    // The prescaler only advances while the state is unchanged; any transition drops partial progress.
    if (alvo == state_q) begin
      case (state_q)
        DESCARGA: begin
          if (cnt_q == FIM_DESC) begin
            if (nivel_q <= 4'd1) begin
              nivel_d = 4'd0;
              state_d = ESGOTADA;
            end else begin
              nivel_d = nivel_q - 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CARGA: begin
          if (cnt_q == FIM_CARGA) begin
            if (nivel_q >= 4'd8) begin
              nivel_d = NIVEL_MAX;
              state_d = PARADO;
            end else begin
              nivel_d = nivel_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PARADO;
      nivel_q <= NIVEL_MAX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      nivel_q <= nivel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.nivel            = nivel_q;
  assign bus.led0             = (nivel_q > 4'd0);
  assign bus.led1             = (nivel_q > 4'd1);
  assign bus.led2             = (nivel_q > 4'd2);
  assign bus.led3             = (nivel_q > 4'd3);
  assign bus.led4             = (nivel_q > 4'd4);
  assign bus.led5             = (nivel_q > 4'd5);
  assign bus.led6             = (nivel_q > 4'd6);
  assign bus.led7             = (nivel_q > 4'd7);
  assign bus.led8             = (nivel_q > 4'd8);
  assign bus.bateria_baixa    = (nivel_q <= 4'(NIVEL_BAIXO));
  assign bus.carregando       = (state_q == CARGA);
  assign bus.motor_habilitado = (state_q == DESCARGA);
  assign bus.vazia            = (state_q == ESGOTADA);

endmodule

// File: tb/tb_controle_bateria.sv
// Bench for controle_bateria: directed scenarios plus randomized docking/power traffic,
// all checked every cycle against a behavioural battery model.
module tb_controle_bateria;

  localparam int TD = 4;
  localparam int TC = 2;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic reset;
  logic ligar_v, na_base_v;

  controle_bateria_if bus ();
  assign bus.ligar   = ligar_v;
  assign bus.na_base = na_base_v;

  controle_bateria #(
    .TICKS_DESC (TD),
    .TICKS_CARGA(TC),
    .NIVEL_BAIXO(NB),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: level plus the number of whole edges spent in the current activity.
  typedef enum {M_IDLE, M_RUN, M_CHG, M_EMPTY} mode_t;
  mode_t m_mode;
  int    m_level;
  int    m_spent;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_level = 9;
    m_spent = 0;
  endtask

  task automatic model_edge(input bit l, input bit nb);
    mode_t want;
    if (nb)                     want = (m_level < 9) ? M_CHG : M_IDLE;
    else if (m_mode == M_EMPTY) want = M_EMPTY;
    else                        want = l ? M_RUN : M_IDLE;

    if (want != m_mode) begin
      m_mode  = want;
      m_spent = 0;
    end else if (m_mode == M_RUN) begin
      m_spent++;
      if (m_spent == TD) begin
        m_spent = 0;
        m_level = (m_level > 0) ? m_level - 1 : 0;
        if (m_level == 0) m_mode = M_EMPTY;
      end
    end else if (m_mode == M_CHG) begin
      m_spent++;
      if (m_spent == TC) begin
        m_spent = 0;
        m_level = (m_level < 9) ? m_level + 1 : 9;
        if (m_level == 9) m_mode = M_IDLE;
      end
    end
  endtask

  function automatic logic [8:0] leds();
    return {bus.led8, bus.led7, bus.led6, bus.led5, bus.led4,
            bus.led3, bus.led2, bus.led1, bus.led0};
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".nivel"},  32'(bus.nivel),            32'(m_level));
    check({tag, ".leds"},   32'(leds()),               32'((1 << m_level) - 1));
    check({tag, ".baixa"},  32'(bus.bateria_baixa),    32'(m_level <= NB));
    check({tag, ".carreg"}, 32'(bus.carregando),       32'(m_mode == M_CHG));
    check({tag, ".motor"},  32'(bus.motor_habilitado), 32'(m_mode == M_RUN));
    check({tag, ".vazia"},  32'(bus.vazia),            32'(m_mode == M_EMPTY));
  endtask

  // Inputs change just after the falling edge; outputs are sampled on the falling edge.
  task automatic run_edges(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge(ligar_v, na_base_v);
      @(negedge clk);
      compare_all(tag);
    end
  endtask

  initial begin
    reset     = 1'b1;
    ligar_v   = 1'b0;
    na_base_v = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    compare_all("reset");
    check("reset.leds_const", 32'(leds()), 32'h1ff);

    // Full discharge from 9; edge 0 is the first edge seeing ligar=1.
    ligar_v = 1'b1;
    run_edges(5, "drain");
    check("drain.e4", 32'(bus.nivel), 32'd8);
    run_edges(4, "drain");
    check("drain.e8", 32'(bus.nivel), 32'd7);
    run_edges(19, "drain");
    check("drain.e27_baixa", 32'(bus.bateria_baixa), 32'd0);
    run_edges(1, "drain");
    check("drain.e28_baixa", 32'(bus.bateria_baixa), 32'd1);
    check("drain.e28_nivel", 32'(bus.nivel), 32'd2);
    run_edges(8, "drain");
    check("drain.e36_nivel", 32'(bus.nivel), 32'd0);
    check("drain.e36_vazia", 32'(bus.vazia), 32'd1);
    check("drain.e36_motor", 32'(bus.motor_habilitado), 32'd0);
    check("drain.e36_leds", 32'(leds()), 32'd0);

    for (int i = 0; i < 6; i++) begin
      ligar_v = ~ligar_v;
      run_edges(2, "esgotada");
    end
    check("esgotada.hold", 32'(bus.vazia), 32'd1);

    // Recharge from empty.
    na_base_v = 1'b1;
    run_edges(1, "charge");
    check("charge.enter", 32'(bus.carregando), 32'd1);
    run_edges(2, "charge");
    check("charge.step1", 32'(bus.nivel), 32'd1);
    run_edges(15, "charge");
    check("charge.e17", 32'(bus.nivel), 32'd8);
    run_edges(1, "charge");
    check("charge.full", 32'(bus.nivel), 32'd9);
    check("charge.idle", 32'(bus.carregando), 32'd0);

    // Drain to 5, dock for two edges (cnt=1), then undock with ligar high.
    na_base_v = 1'b0;
    ligar_v   = 1'b1;
    run_edges(17, "pre_int");
    check("pre_int.nivel", 32'(bus.nivel), 32'd5);
    na_base_v = 1'b1;
    run_edges(2, "interrupt");
    na_base_v = 1'b0;
    run_edges(1, "interrupt");
    check("interrupt.motor", 32'(bus.motor_habilitado), 32'd1);
    run_edges(3, "interrupt");
    check("interrupt.e3", 32'(bus.nivel), 32'd5);
    run_edges(1, "interrupt");
    check("interrupt.e4", 32'(bus.nivel), 32'd4);

    // Charge back to full, then stay docked with ligar high.
    na_base_v = 1'b1;
    run_edges(11, "dock_full");
    run_edges(50, "dock_full");
    check("dock_full.nivel", 32'(bus.nivel), 32'd9);
    check("dock_full.motor", 32'(bus.motor_habilitado), 32'd0);

    // Pause mid-discharge at cnt=3, then resume.
    na_base_v = 1'b0;
    run_edges(4, "pause");
    ligar_v = 1'b0;
    run_edges(1, "pause");
    check("pause.nivel", 32'(bus.nivel), 32'd9);
    check("pause.motor", 32'(bus.motor_habilitado), 32'd0);
    ligar_v = 1'b1;
    run_edges(4, "resume");
    check("resume.e3", 32'(bus.nivel), 32'd9);
    run_edges(1, "resume");
    check("resume.e4", 32'(bus.nivel), 32'd8);

    // Asynchronous reset between edges while discharging.
    run_edges(2, "pre_rst");
    #2 reset = 1'b1;
    #1;
    check("async_rst.nivel", 32'(bus.nivel), 32'd9);
    check("async_rst.motor", 32'(bus.motor_habilitado), 32'd0);
    check("async_rst.leds", 32'(leds()), 32'h1ff);
    model_reset();
    ligar_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    compare_all("post_rst");

    // Randomized docking / power traffic with sticky inputs.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) ligar_v   = 1'($urandom);
      if ($urandom_range(15) == 0) na_base_v = 1'($urandom);
      run_edges(1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
